ddr3_lane_read_training_ctrl: RTL and testbench

Per-lane read-training sequencer for the DDR3 PHY byte lanes.
- Drives the dynamic delay-line and eye-monitor controls of NUM_DQ IOD data bits.
- Trains one bit at a time: sweeps the input delay tap by tap and finds the passing window from the EYE_MONITOR_EARLY/LATE flags.
- Parks each bit at the window centre.
- Sits between the training state machine of the PHY and the lane's IOD instances. It replaces static per-bit delay tuning.

---
 rtl/ddr3_lane_read_training_ctrl_if.sv | 32 +++
 rtl/ddr3_lane_read_training_ctrl.sv | 249 ++++++++++++++++++++++++
 tb/tb_ddr3_lane_read_training_ctrl.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_lane_read_training_ctrl_if.sv
// Training-control and IOD delay-line / eye-monitor signals of one DDR3 byte lane.
// master = the lane read-training sequencer, slave = PHY training FSM plus IOD bits.
interface ddr3_lane_read_training_ctrl_if #(
    parameter int NUM_DQ = 8,
    parameter int TAP_W  = 7
);
    logic                        TRAIN_START;
    logic                        TRAIN_BUSY;
    logic                        TRAIN_DONE;
    logic [NUM_DQ-1:0]           TRAIN_FAIL;
    logic [NUM_DQ*TAP_W-1:0]     EYE_CENTER;
    logic [NUM_DQ*(TAP_W+1)-1:0] EYE_WIDTH;
    logic [NUM_DQ-1:0]           DELAY_LINE_MOVE;
    logic [NUM_DQ-1:0]           DELAY_LINE_DIRECTION;
    logic [NUM_DQ-1:0]           DELAY_LINE_LOAD;
    logic [NUM_DQ-1:0]           EYE_MONITOR_CLEAR_FLAGS;
    logic [NUM_DQ-1:0]           EYE_MONITOR_EARLY;
    logic [NUM_DQ-1:0]           EYE_MONITOR_LATE;
    logic [NUM_DQ-1:0]           DELAY_LINE_OUT_OF_RANGE;

    modport master (
        input  TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        output TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, EYE_CENTER, EYE_WIDTH,
               DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS
    );

    modport slave (
        output TRAIN_START, EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE,
        input  TRAIN_BUSY, TRAIN_DONE, TRAIN_FAIL, EYE_CENTER, EYE_WIDTH,
               DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, DELAY_LINE_LOAD, EYE_MONITOR_CLEAR_FLAGS
    );
endinterface

// File: rtl/ddr3_lane_read_training_ctrl.sv
// Per-bit read-eye sweep: finds the passing tap window of each DQ bit and parks it at the centre.
// Per tap 1+SETTLE+SAMPLE+1 cycles (+1 step); START is only accepted in IDLE, never stalls the IOD.
module ddr3_lane_read_training_ctrl #(
    parameter int NUM_DQ        = 8,
    parameter int MAX_TAP       = 127,
    parameter int TAP_W         = 7,
    parameter int SETTLE_CYCLES = 4,
    parameter int SAMPLE_CYCLES = 16,
    parameter int MIN_EYE_WIDTH = 8
) (
    input  logic                                   FAB_CLK,
    input  logic                                   RX_SYNC_RST,
    ddr3_lane_read_training_ctrl_if.master         lane
);
    localparam int TW1     = TAP_W + 1;
    localparam int CNT_MAX = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int B_W     = (NUM_DQ > 1) ? $clog2(NUM_DQ) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_CLEAR, S_SETTLE, S_SAMPLE, S_EVAL, S_STEP,
        S_CLOAD, S_CMOVE, S_NEXT, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [B_W-1:0]          b_q, b_d;
    logic [TAP_W-1:0]        tap_q, tap_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    bad_q, bad_d;
    logic                    oor_q, oor_d;
    logic [TAP_W-1:0]        first_q, first_d;
    logic                    first_vld_q, first_vld_d;
    logic [TAP_W-1:0]        last_q, last_d;
    logic [TAP_W-1:0]        mcnt_q, mcnt_d;
    logic                    phase_q, phase_d;
    logic [TW1-1:0]          win_q, win_d;
    logic [TAP_W-1:0]        centre_q, centre_d;
    logic                    cfail_q, cfail_d;
    logic                    done_q, done_d;
    logic [NUM_DQ-1:0]       fail_q, fail_d;
    logic [NUM_DQ*TAP_W-1:0] center_q, center_d;
    logic [NUM_DQ*TW1-1:0]   width_q, width_d;

    logic [TW1-1:0]          width_c;
    logic [TW1-1:0]          sum_c;
    logic [TAP_W-1:0]        centre_c;
    logic                    fail_c;
    logic                    early_b, late_b, oor_b;
    logic [NUM_DQ-1:0]       move_strb, load_strb, clr_strb;

    assign early_b = lane.EYE_MONITOR_EARLY[b_q];
    assign late_b  = lane.EYE_MONITOR_LATE[b_q];
    assign oor_b   = lane.DELAY_LINE_OUT_OF_RANGE[b_q];

    // Window arithmetic is one bit wider than a tap so last-first+1 and first+last never wrap.
    always_comb begin
        width_c  = first_vld_q ? (TW1'({1'b0, last_q}) - TW1'({1'b0, first_q}) + TW1'(1)) : '0;
        sum_c    = TW1'({1'b0, first_q}) + TW1'({1'b0, last_q});
        fail_c   = (width_c < TW1'(MIN_EYE_WIDTH));
        centre_c = fail_c ? '0 : TAP_W'(sum_c >> 1);
    end

    always_comb begin
        state_d     = state_q;
        b_d         = b_q;
        tap_d       = tap_q;
        cnt_d       = cnt_q;
        bad_d       = bad_q;
        oor_d       = oor_q;
        first_d     = first_q;
        first_vld_d = first_vld_q;
        last_d      = last_q;
        mcnt_d      = mcnt_q;
        phase_d     = phase_q;
        win_d       = win_q;
        centre_d    = centre_q;
        cfail_d     = cfail_q;
        done_d      = done_q;
        fail_d      = fail_q;
        center_d    = center_q;
        width_d     = width_q;

        case (state_q)
            S_IDLE: begin
                if (lane.TRAIN_START) begin
                    done_d      = 1'b0;
                    fail_d      = '0;
                    b_d         = '0;
                    first_vld_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                tap_d   = '0;
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                bad_d   = 1'b0;
                oor_d   = 1'b0;
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_SAMPLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SAMPLE: begin
                // A saturated delay line poisons the tap even if the eye flags stay clean.
                bad_d = bad_q | early_b | late_b | oor_b;
                oor_d = oor_q | oor_b;
                if (cnt_q == CNT_W'(SAMPLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_EVAL;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_EVAL: begin
                if (!bad_q) begin
                    if (!first_vld_q) begin
                        first_d     = tap_q;
                        first_vld_d = 1'b1;
                    end
                    last_d = tap_q;
                end
                if ((bad_q && first_vld_q) || (tap_q == TAP_W'(MAX_TAP)) || oor_q) begin
                    state_d = S_CLOAD;
                end else begin
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                tap_d   = tap_q + TAP_W'(1);
                state_d = S_CLEAR;
            end
            S_CLOAD: begin
                win_d    = width_c;
                cfail_d  = fail_c;
                centre_d = centre_c;
                mcnt_d   = centre_c;
                phase_d  = 1'b0;
                state_d  = S_CMOVE;
            end
            S_CMOVE: begin
                if (mcnt_q != '0) begin
                    // Moves alternate strobe / gap so the IOD sees distinct increments.
                    if (!phase_q) begin
                        mcnt_d  = mcnt_q - TAP_W'(1);
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                    end
                end else begin
                    center_d[int'(b_q)*TAP_W +: TAP_W] = centre_q;
                    width_d[int'(b_q)*TW1 +: TW1]      = win_q;
                    fail_d[b_q]                        = cfail_q;
                    state_d                            = S_NEXT;
                end
            end
            S_NEXT: begin
                if (b_q == B_W'(NUM_DQ - 1)) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    b_d         = b_q + B_W'(1);
                    first_vld_d = 1'b0;
                    state_d     = S_LOAD;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        move_strb = '0;
        load_strb = '0;
        clr_strb  = '0;
        if ((state_q == S_LOAD) || (state_q == S_CLOAD)) begin
            load_strb[b_q] = 1'b1;
        end
        if (state_q == S_CLEAR) begin
            clr_strb[b_q] = 1'b1;
        end
        if ((state_q == S_STEP) || ((state_q == S_CMOVE) && (mcnt_q != '0) && !phase_q)) begin
            move_strb[b_q] = 1'b1;
        end
    end

    always_ff @(posedge FAB_CLK) begin
        if (RX_SYNC_RST) begin
            state_q     <= S_IDLE;
            b_q         <= '0;
            tap_q       <= '0;
            cnt_q       <= '0;
            bad_q       <= 1'b0;
            oor_q       <= 1'b0;
            first_q     <= '0;
            first_vld_q <= 1'b0;
            last_q      <= '0;
            mcnt_q      <= '0;
            phase_q     <= 1'b0;
            win_q       <= '0;
            centre_q    <= '0;
            cfail_q     <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= '0;
            center_q    <= '0;
            width_q     <= '0;
        end else begin
            state_q     <= state_d;
            b_q         <= b_d;
            tap_q       <= tap_d;
            cnt_q       <= cnt_d;
            bad_q       <= bad_d;
            oor_q       <= oor_d;
            first_q     <= first_d;
            first_vld_q <= first_vld_d;
            last_q      <= last_d;
            mcnt_q      <= mcnt_d;
            phase_q     <= phase_d;
            win_q       <= win_d;
            centre_q    <= centre_d;
            cfail_q     <= cfail_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            center_q    <= center_d;
            width_q     <= width_d;
        end
    end

    assign lane.TRAIN_BUSY              = (state_q != S_IDLE) && (state_q != S_DONE);
    assign lane.TRAIN_DONE              = done_q;
    assign lane.TRAIN_FAIL              = fail_q;
    assign lane.EYE_CENTER              = center_q;
    assign lane.EYE_WIDTH               = width_q;
    assign lane.DELAY_LINE_MOVE         = move_strb;
    assign lane.DELAY_LINE_DIRECTION    = '1;
    assign lane.DELAY_LINE_LOAD         = load_strb;
    assign lane.EYE_MONITOR_CLEAR_FLAGS = clr_strb;
endmodule

// File: tb/tb_ddr3_lane_read_training_ctrl.sv
// Directed bench: per-bit eye windows from a table, an IOD tap model, and reset/abort sequences.
module tb_ddr3_lane_read_training_ctrl;
    localparam int NUM_DQ = 8;
    localparam int TAP_W  = 7;
    localparam int TW1    = TAP_W + 1;
    localparam int BUDGET = 20000;
    localparam int NO_OOR = 999;

    typedef struct {
        int lo;
        int hi;
        int oor;
        int c;
        int w;
        int f;
        int end_t;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic run_clr;
    always #5 clk = ~clk;

    ddr3_lane_read_training_ctrl_if #(.NUM_DQ(NUM_DQ), .TAP_W(TAP_W)) bus ();

    ddr3_lane_read_training_ctrl #(
        .NUM_DQ(NUM_DQ), .MAX_TAP(127), .TAP_W(TAP_W),
        .SETTLE_CYCLES(4), .SAMPLE_CYCLES(16), .MIN_EYE_WIDTH(8)
    ) dut (
        .FAB_CLK    (clk),
        .RX_SYNC_RST(rst),
        .lane       (bus.master)
    );

    vec_t vecs [16];
    int   lo [NUM_DQ];
    int   hi [NUM_DQ];
    int   oor_at [NUM_DQ];

    int   tap_m [NUM_DQ];
    int   load_cnt [NUM_DQ];
    int   cmove_cnt [NUM_DQ];
    int   end_tap [NUM_DQ];
    int   viol;
    int   last_idx;
    int   first_idx;
    int   done_rises;
    int   strobe_total;
    logic done_prev;

    int   n_cmp = 0;
    int   n_bad = 0;

    logic [NUM_DQ-1:0] early, late, oorv;

    // Eye model: a bit passes only while its delay sits inside [lo, hi] and below the saturation tap.
    always_comb begin
        early = '0;
        late  = '0;
        oorv  = '0;
        for (int i = 0; i < NUM_DQ; i++) begin
            early[i] = (tap_m[i] < lo[i]);
            late[i]  = (tap_m[i] > hi[i]);
            oorv[i]  = (tap_m[i] >= oor_at[i]);
        end
    end

    assign bus.EYE_MONITOR_EARLY       = early;
    assign bus.EYE_MONITOR_LATE        = late;
    assign bus.DELAY_LINE_OUT_OF_RANGE = oorv;
    assign bus.TRAIN_START             = start;

    initial begin
        for (int i = 0; i < NUM_DQ; i++) begin
            tap_m[i]     = 0;
            load_cnt[i]  = 0;
            cmove_cnt[i] = 0;
            end_tap[i]   = -1;
        end
        viol = 0; last_idx = 0; first_idx = -1; done_rises = 0; strobe_total = 0; done_prev = 1'b0;
    end

    always @(negedge clk) begin
        strobe_total <= strobe_total + $countones({bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD,
                                                   bus.EYE_MONITOR_CLEAR_FLAGS});
        for (int i = 0; i < NUM_DQ; i++) begin
            if (bus.DELAY_LINE_LOAD[i]) begin
                tap_m[i] <= 0;
            end else if (bus.DELAY_LINE_MOVE[i]) begin
                tap_m[i] <= tap_m[i] + 1;
            end
        end
        if (run_clr) begin
            for (int i = 0; i < NUM_DQ; i++) begin
                load_cnt[i]  <= 0;
                cmove_cnt[i] <= 0;
                end_tap[i]   <= -1;
            end
            viol <= 0; last_idx <= 0; first_idx <= -1; done_rises <= 0;
        end else begin
            if (($countones({bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD, bus.EYE_MONITOR_CLEAR_FLAGS}) > 1) ||
                ((bus.DELAY_LINE_MOVE & ~bus.DELAY_LINE_DIRECTION) != '0))
                viol <= viol + 1;
            for (int i = 0; i < NUM_DQ; i++) begin
                if (bus.DELAY_LINE_MOVE[i] | bus.DELAY_LINE_LOAD[i] | bus.EYE_MONITOR_CLEAR_FLAGS[i]) begin
                    if (i < last_idx) viol <= viol + 1;
                    last_idx <= i;
                    if (first_idx < 0) first_idx <= i;
                end
                if (bus.DELAY_LINE_LOAD[i]) begin
                    load_cnt[i] <= load_cnt[i] + 1;
                    if (load_cnt[i] == 1) end_tap[i] <= tap_m[i];
                end else if (bus.DELAY_LINE_MOVE[i] && load_cnt[i] >= 2) begin
                    cmove_cnt[i] <= cmove_cnt[i] + 1;
                end
            end
            if (bus.TRAIN_DONE && !done_prev) done_rises <= done_rises + 1;
        end
        done_prev <= bus.TRAIN_DONE;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"},   longint'(bus.TRAIN_BUSY), 0);
        chk({tag, "_done"},   longint'(bus.TRAIN_DONE), 0);
        chk({tag, "_fail"},   longint'(bus.TRAIN_FAIL), 0);
        chk({tag, "_center"}, longint'(bus.EYE_CENTER), 0);
        chk({tag, "_width"},  longint'(bus.EYE_WIDTH), 0);
        chk({tag, "_strobes"}, longint'({bus.DELAY_LINE_MOVE, bus.DELAY_LINE_LOAD,
                                         bus.EYE_MONITOR_CLEAR_FLAGS}), 0);
        chk({tag, "_dir"},    longint'(bus.DELAY_LINE_DIRECTION), 255);
    endtask

    task automatic load_windows(input int base);
        for (int i = 0; i < NUM_DQ; i++) begin
            lo[i]     = vecs[base + i].lo;
            hi[i]     = vecs[base + i].hi;
            oor_at[i] = vecs[base + i].oor;
        end
    endtask

    task automatic clear_stats();
        run_clr = 1'b1;
        tick();
        run_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        chk("busy_after_start", longint'(bus.TRAIN_BUSY), 1);
        chk("done_cleared_by_start", longint'(bus.TRAIN_DONE), 0);
        start = 1'b0;
    endtask

    task automatic run_train(input int base, input bit extra_starts);
        int cyc;
        load_windows(base);
        clear_stats();
        pulse_start();
        cyc = 0;
        while (!bus.TRAIN_DONE && cyc < BUDGET) begin
            tick();
            cyc++;
            start = (extra_starts && (cyc % 1000 == 0)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("done_within_budget", longint'(cyc < BUDGET), 1);
        chk("busy_low_with_done", longint'(bus.TRAIN_BUSY), 0);
        tick();
        tick();
        chk("done_held", longint'(bus.TRAIN_DONE), 1);
        chk("done_rises", done_rises, 1);
        chk("strobe_rule_violations", viol, 0);
        chk("first_strobe_bit", first_idx, 0);
        for (int i = 0; i < NUM_DQ; i++) begin
            chk($sformatf("center[%0d]", i), longint'(bus.EYE_CENTER[i*TAP_W +: TAP_W]), vecs[base+i].c);
            chk($sformatf("width[%0d]", i), longint'(bus.EYE_WIDTH[i*TW1 +: TW1]), vecs[base+i].w);
            chk($sformatf("fail[%0d]", i), longint'(bus.TRAIN_FAIL[i]), vecs[base+i].f);
            chk($sformatf("loads[%0d]", i), load_cnt[i], 2);
            chk($sformatf("center_moves[%0d]", i), cmove_cnt[i], vecs[base+i].c);
            chk($sformatf("sweep_end_tap[%0d]", i), end_tap[i], vecs[base+i].end_t);
            chk($sformatf("parked_tap[%0d]", i), tap_m[i], vecs[base+i].c);
        end
    endtask

    task automatic reset_abort();
        int cyc;
        int snap;
        load_windows(8);
        clear_stats();
        pulse_start();
        cyc = 0;
        while (load_cnt[2] == 0 && cyc < BUDGET) begin
            tick();
            cyc++;
        end
        chk("reached_bit2", longint'(cyc < BUDGET), 1);
        // Now in CLEAR of bit2: skip the 4 settle cycles and land inside SAMPLE.
        repeat (6) tick();
        rst = 1'b1;
        tick();
        chk_reset("mid_sweep_reset");
        rst = 1'b0;
        snap = strobe_total;
        repeat (60) tick();
        chk("strobes_after_abort", strobe_total - snap, 0);
        chk("idle_after_abort", longint'(bus.TRAIN_BUSY), 0);
    endtask

    initial begin
        vecs[0] = '{20,  60, NO_OOR, 40,  41, 0, 61};
        vecs[1] = '{11,  31, NO_OOR, 21,  21, 0, 32};
        vecs[2] = '{100, 127, NO_OOR, 113, 28, 0, 127};
        vecs[3] = '{200, -1, NO_OOR, 0,   0,  1, 127};
        vecs[4] = '{5,   9,  NO_OOR, 0,   5,  1, 10};
        vecs[5] = '{40,  90, 50,     44,  10, 0, 50};
        vecs[6] = '{16,  36, NO_OOR, 26,  21, 0, 37};
        vecs[7] = '{17,  37, NO_OOR, 27,  21, 0, 38};
        for (int i = 0; i < NUM_DQ; i++) begin
            vecs[8 + i] = '{10 + i, 30 + i, NO_OOR, 20 + i, 21, 0, 31 + i};
        end
        for (int i = 0; i < NUM_DQ; i++) begin
            lo[i] = 0;
            hi[i] = 127;
            oor_at[i] = NO_OOR;
        end

        rst = 1'b1;
        start = 1'b0;
        run_clr = 1'b0;
        repeat (3) tick();
        chk_reset("power_on_reset");
        rst = 1'b0;
        tick();

        run_train(0, 1'b1);
        run_train(8, 1'b0);
        reset_abort();
        run_train(8, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
